// File: rtl/serial_compare.sv
// Multi-cycle magnitude comparator: walks both operands MSB-first, DIGIT bits per
// clock, and stops at the first differing chunk. Signed compares use an MSB flip.
module serial_compare #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [DIGIT-1:0] chunk_a;
    logic [DIGIT-1:0] chunk_b;

    assign chunk_a = a_q[WIDTH-1 -: DIGIT];
    assign chunk_b = b_q[WIDTH-1 -: DIGIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    a_d            = a;
                    b_d            = b;
                    a_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
                    b_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
                    cnt_d          = CW'(N);
                    state_d        = RUN;
                end
            end
            RUN: begin
                if (chunk_a != chunk_b) begin
                    state_d = DONE;
                    eq_d    = 1'b0;
                    gt_d    = (chunk_a > chunk_b);
                    lt_d    = (chunk_a < chunk_b);
                end else if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end else begin
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign aeqb  = eq_q;
    assign agtb  = gt_q;
    assign altb  = lt_q;

endmodule

// File: tb/tb_serial_compare.sv
// Directed bench for serial_compare: an 8-bit/2-bit-digit instance and a
// 4-bit/1-bit-digit instance, checked against hand-computed latencies and flags.
module tb_serial_compare;
    logic       clk = 1'b0;
    logic       reset;
    logic       start8, sm8, start4, sm4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       ready8, done8, eq8, gt8, lt8;
    logic       ready4, done4, eq4, gt4, lt4;

    logic       sel;
    logic       o_ready, o_done, o_eq, o_gt, o_lt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_compare #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .ready(ready8), .done(done8),
        .aeqb(eq8), .agtb(gt8), .altb(lt8)
    );

    serial_compare #(.WIDTH(4), .DIGIT(1)) u4 (
        .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .ready(ready4), .done(done4),
        .aeqb(eq4), .agtb(gt4), .altb(lt4)
    );

    always_comb begin
        o_ready = ready8;
        o_done  = done8;
        o_eq    = eq8;
        o_gt    = gt8;
        o_lt    = lt8;
        if (sel) begin
            o_ready = ready4;
            o_done  = done4;
            o_eq    = eq4;
            o_gt    = gt4;
            o_lt    = lt4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one compare, returns after the cycle following done.
    task automatic run_cmp(input logic use4, input string tag, input logic [7:0] av,
                           input logic [7:0] bv, input logic smv, input int exp_cyc,
                           input logic e_eq, input logic e_gt, input logic e_lt);
        int cyc;
        sel = use4;
        chk({tag, "_ready_before"}, 32'(o_ready), 32'd1);
        if (use4) begin
            start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; sm4 = smv;
        end else begin
            start8 = 1'b1; a8 = av; b8 = bv; sm8 = smv;
        end
        step();
        start4 = 1'b0; start8 = 1'b0;
        a8 = ~av; b8 = bv ^ 8'h5A; sm8 = ~smv;
        a4 = ~av[3:0]; b4 = ~bv[3:0]; sm4 = ~smv;
        cyc = 1;
        while (!o_done && cyc < 20) begin
            step();
            cyc++;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_ready_in_done"}, 32'(o_ready), 32'd0);
        chk({tag, "_flags"}, {29'd0, o_eq, o_gt, o_lt}, {29'd0, e_eq, e_gt, e_lt});
        step();
        chk({tag, "_after_done"}, {29'd0, o_ready, o_done, (o_eq ^ o_gt ^ o_lt)},
            {29'd0, 1'b1, 1'b0, 1'b1});
        chk({tag, "_flags_hold"}, {29'd0, o_eq, o_gt, o_lt}, {29'd0, e_eq, e_gt, e_lt});
    endtask

    initial begin
        int cyc;
        int pulses;
        sel = 1'b0;
        reset = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        step();
        step();
        chk("reset_state8", {27'd0, ready8, done8, eq8, gt8, lt8}, {27'd0, 5'b10000});
        chk("reset_state4", {27'd0, ready4, done4, eq4, gt4, lt4}, {27'd0, 5'b10000});

        // Reset must win over a simultaneous start.
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        step();
        start8 = 1'b0;
        chk("reset_over_start", {30'd0, ready8, done8}, {30'd0, 2'b10});
        reset = 1'b0;
        step();
        chk("idle_no_start", {30'd0, ready8, done8}, {30'd0, 2'b10});

        run_cmp(1'b0, "eq_A5",       8'hA5, 8'hA5, 1'b0, 5, 1'b1, 1'b0, 1'b0);
        run_cmp(1'b0, "uns_80_7F",   8'h80, 8'h7F, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        run_cmp(1'b0, "sgn_80_7F",   8'h80, 8'h7F, 1'b1, 2, 1'b0, 1'b0, 1'b1);
        run_cmp(1'b0, "uns_12_13",   8'h12, 8'h13, 1'b0, 5, 1'b0, 1'b0, 1'b1);
        run_cmp(1'b0, "uns_0C_08",   8'h0C, 8'h08, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        run_cmp(1'b0, "sgn_37_35",   8'h37, 8'h35, 1'b1, 5, 1'b0, 1'b1, 1'b0);
        run_cmp(1'b0, "sgn_FF_FE",   8'hFF, 8'hFE, 1'b1, 5, 1'b0, 1'b1, 1'b0);
        run_cmp(1'b0, "sgn_00_FF",   8'h00, 8'hFF, 1'b1, 2, 1'b0, 1'b1, 1'b0);

        // Start while busy is ignored; only one done pulse for the original operands.
        sel = 1'b0;
        start8 = 1'b1; a8 = 8'h40; b8 = 8'h41; sm8 = 1'b0;
        step();
        start8 = 1'b0;
        step();
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        cyc = 2;
        pulses = 0;
        step();
        start8 = 1'b0;
        cyc = 3;
        while (!done8 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("busy_start_done_cycle", 32'(cyc), 32'd5);
        chk("busy_start_flags", {29'd0, eq8, gt8, lt8}, {29'd0, 3'b001});
        for (int i = 0; i < 8; i++) begin
            if (done8) pulses++;
            step();
        end
        chk("busy_start_pulses", 32'(pulses), 32'd1);

        // Reset in the middle of RUN aborts the compare.
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h03;
        step();
        start8 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_state", {27'd0, ready8, done8, eq8, gt8, lt8}, {27'd0, 5'b10000});
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done8) pulses++;
            step();
        end
        chk("abort_no_done", 32'(pulses), 32'd0);

        run_cmp(1'b1, "w4_sgn_F_0",  8'h0F, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b1);
        run_cmp(1'b1, "w4_uns_F_0",  8'h0F, 8'h00, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        run_cmp(1'b1, "w4_eq_9",     8'h09, 8'h09, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        run_cmp(1'b1, "w4_uns_4_5",  8'h04, 8'h05, 1'b0, 5, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
